// File: rtl/uart_pkg.sv
// uart_pkg: shared state encodings and data width for the button-driven UART transmitter.
// Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

package uart_pkg;

  localparam int UART_DW = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
  localparam logic [2:0] ST_PARITY = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_STOP   = ST_STOP,
    S_PARITY = ST_PARITY
  } uart_state_e;

  function automatic logic even_parity(input logic [UART_DW-1:0] d);
    return ^d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count; a pop frees a slot for a same-edge push.
// Revision: 1.0
`timescale 1ns/1ps
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

`default_nettype wire

// File: rtl/btn_uart_tx.sv
// btn_uart_tx: queues switch bytes on each press pulse and sends them as 8N1 UART frames.
// Revision: 1.0. Define BTN_UART_PARITY_EN for 8E1 frames with an even parity bit.
`timescale 1ns/1ps
`default_nettype none

module btn_uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          press,
  input  logic [UART_DW-1:0]            sw_data,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          overflow
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

  uart_state_e        state_q;
  logic [BW-1:0]      baud_q;
  logic [2:0]         bit_q;
  logic [UART_DW-1:0] shift_q;
  logic               tx_q;
  logic               overflow_q;
`ifdef BTN_UART_PARITY_EN
  logic               parity_q;
`endif

  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [UART_DW-1:0] fifo_rdata;
  logic               baud_done;

  assign pop       = (state_q == S_IDLE) & ~fifo_empty;
  assign baud_done = (baud_q == BAUD_LAST);

  sync_fifo #(
    .WIDTH (UART_DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (press),
    .wdata_i (sw_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // tx_q always takes the level of the state being entered, so the line never glitches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef BTN_UART_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (!fifo_empty) begin
            shift_q <= fifo_rdata;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b0;
            state_q <= S_START;
`ifdef BTN_UART_PARITY_EN
            parity_q <= even_parity(fifo_rdata);
`endif
          end
        end
        S_START: begin
          if (baud_done) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        S_DATA: begin
          if (baud_done) begin
            baud_q  <= '0;
            shift_q <= shift_q >> 1;
            if (bit_q == 3'd7) begin
`ifdef BTN_UART_PARITY_EN
              tx_q    <= parity_q;
              state_q <= S_PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= S_STOP;
`endif
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
`ifdef BTN_UART_PARITY_EN
        S_PARITY: begin
          if (baud_done) begin
            baud_q  <= '0;
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
`endif
        S_STOP: begin
          if (baud_done) begin
            baud_q  <= '0;
            tx_q    <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // A push while full is only lost when the FSM is not popping on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overflow_q <= 1'b0;
    else      overflow_q <= press & fifo_full & ~pop;
  end

  assign tx       = tx_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != S_IDLE) | (fifo_cnt != '0);

endmodule

`default_nettype wire

// File: tb/tb_btn_uart_tx.sv
// tb_btn_uart_tx: directed self-checking bench for btn_uart_tx at DIV=10.
`timescale 1ns/1ps
`default_nettype none

module tb_btn_uart_tx;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 100000;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int DEPTH    = 4;
`ifdef BTN_UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       press = 1'b0;
  logic [7:0] sw_data = 8'h00;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_cnt;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  btn_uart_tx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .press    (press),
    .sw_data  (sw_data),
    .tx       (tx),
    .busy     (busy),
    .fifo_cnt (fifo_cnt),
    .overflow (overflow)
  );

  // Called on the negedge holding frame sample index `skip`; returns on the last frame sample.
  task automatic expect_frame(input logic [7:0] b, input int skip);
    logic lvl;
    int   errs;
    int   s;
    bit   seen;
    for (int p = 0; p < NB; p++) begin
      if (p == 0)                  lvl = 1'b0;
      else if (p <= 8)             lvl = b[p-1];
      else if (p == 9 && NB == 11) lvl = ^b;
      else                         lvl = 1'b1;
      errs = 0;
      seen = 1'b0;
      for (int c = 0; c < DIV; c++) begin
        s = p * DIV + c;
        if (s >= skip) begin
          seen = 1'b1;
          if (tx !== lvl || busy !== 1'b1) errs++;
          if (s != NB * DIV - 1) @(negedge clk);
        end
      end
      if (seen) begin
        total++;
        if (errs != 0) begin
          bad++;
          $display("FAIL frame_%02h_bit%0d: tx=%b busy=%b required tx=%b busy=1 (%0d bad samples)",
                   b, p, tx, busy, lvl, errs);
        end
      end
    end
  endtask

  task automatic idle_then_frame(input logic [7:0] b, input logic [2:0] exp_cnt);
    @(negedge clk);
    total++;
    if (tx !== 1'b1 || busy !== 1'b1 || fifo_cnt !== exp_cnt) begin
      bad++;
      $display("FAIL gap_before_%02h: tx=%b busy=%b cnt=%0d required tx=1 busy=1 cnt=%0d",
               b, tx, busy, fifo_cnt, exp_cnt);
    end
    @(negedge clk);
    expect_frame(b, 0);
  endtask

  task automatic check_quiet(input string name);
    total++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_cnt !== 3'd0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL %s: tx=%b busy=%b cnt=%0d ovf=%b required tx=1 busy=0 cnt=0 ovf=0",
               name, tx, busy, fifo_cnt, overflow);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    press = 1'b1;
    sw_data = 8'hFF;
    repeat (3) @(negedge clk);
    check_quiet("reset_hold");
    press = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    check_quiet("reset_release");
  endtask

  task automatic test_single();
    press = 1'b1; sw_data = 8'hA5;
    @(negedge clk);
    press = 1'b0;
    total++;
    if (fifo_cnt !== 3'd1 || busy !== 1'b1 || tx !== 1'b1) begin
      bad++;
      $display("FAIL single_enqueue: cnt=%0d busy=%b tx=%b required cnt=1 busy=1 tx=1", fifo_cnt, busy, tx);
    end
    @(negedge clk);
    expect_frame(8'hA5, 0);
    @(negedge clk);
    check_quiet("single_end");
  endtask

  task automatic test_back_to_back();
    press = 1'b1; sw_data = 8'h01;
    @(negedge clk);
    sw_data = 8'h02;
    total++;
    if (fifo_cnt !== 3'd1) begin
      bad++; $display("FAIL b2b_cnt_k1: cnt=%0d required 1", fifo_cnt);
    end
    @(negedge clk);
    sw_data = 8'h03;
    total++;
    if (fifo_cnt !== 3'd1 || tx !== 1'b0) begin
      bad++; $display("FAIL b2b_cnt_k2: cnt=%0d tx=%b required cnt=1 tx=0", fifo_cnt, tx);
    end
    @(negedge clk);
    press = 1'b0;
    total++;
    if (fifo_cnt !== 3'd2) begin
      bad++; $display("FAIL b2b_peak: cnt=%0d required 2", fifo_cnt);
    end
    expect_frame(8'h01, 1);
    idle_then_frame(8'h02, 3'd2);
    idle_then_frame(8'h03, 3'd1);
    @(negedge clk);
    check_quiet("b2b_end");
  endtask

  task automatic test_overflow();
    logic [2:0] exp_cnt [5];
    exp_cnt[0] = 3'd1; exp_cnt[1] = 3'd1; exp_cnt[2] = 3'd2; exp_cnt[3] = 3'd3; exp_cnt[4] = 3'd4;
    press = 1'b1; sw_data = 8'h11;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      total++;
      if (overflow !== 1'b0 || fifo_cnt !== exp_cnt[i-1]) begin
        bad++;
        $display("FAIL ovf_fill_k%0d: ovf=%b cnt=%0d required ovf=0 cnt=%0d", i, overflow, fifo_cnt, exp_cnt[i-1]);
      end
      sw_data = 8'h11 + 8'(i);
    end
    @(negedge clk);
    press = 1'b0;
    total++;
    if (overflow !== 1'b1 || fifo_cnt !== 3'd4) begin
      bad++; $display("FAIL ovf_pulse: ovf=%b cnt=%0d required ovf=1 cnt=4", overflow, fifo_cnt);
    end
    @(negedge clk);
    total++;
    if (overflow !== 1'b0) begin
      bad++; $display("FAIL ovf_one_cycle: ovf=%b required 0", overflow);
    end
    expect_frame(8'h11, 5);
    idle_then_frame(8'h12, 3'd4);
    idle_then_frame(8'h13, 3'd3);
    idle_then_frame(8'h14, 3'd2);
    idle_then_frame(8'h15, 3'd1);
    @(negedge clk);
    check_quiet("ovf_end");
  endtask

  task automatic test_full_push_pop();
    press = 1'b1; sw_data = 8'h21;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      sw_data = 8'h21 + 8'(i);
    end
    @(negedge clk);
    press = 1'b0;
    expect_frame(8'h21, 3);
    @(negedge clk);
    total++;
    if (fifo_cnt !== 3'd4 || tx !== 1'b1) begin
      bad++; $display("FAIL fpp_full_idle: cnt=%0d tx=%b required cnt=4 tx=1", fifo_cnt, tx);
    end
    press = 1'b1; sw_data = 8'h26;
    @(negedge clk);
    press = 1'b0;
    total++;
    if (fifo_cnt !== 3'd4 || overflow !== 1'b0 || tx !== 1'b0) begin
      bad++;
      $display("FAIL fpp_accept: cnt=%0d ovf=%b tx=%b required cnt=4 ovf=0 tx=0", fifo_cnt, overflow, tx);
    end
    expect_frame(8'h22, 0);
    idle_then_frame(8'h23, 3'd4);
    idle_then_frame(8'h24, 3'd3);
    idle_then_frame(8'h25, 3'd2);
    idle_then_frame(8'h26, 3'd1);
    @(negedge clk);
    check_quiet("fpp_end");
  endtask

  task automatic test_mid_frame_reset();
    press = 1'b1; sw_data = 8'h55;
    @(negedge clk);
    sw_data = 8'h66;
    @(negedge clk);
    press = 1'b0;
    repeat (44) @(negedge clk);
    total++;
    if (tx !== 1'b0 || fifo_cnt !== 3'd1) begin
      bad++; $display("FAIL rst_pre_bit3: tx=%b cnt=%0d required tx=0 cnt=1", tx, fifo_cnt);
    end
    #2 rst = 1'b0;
    #1;
    check_quiet("rst_async");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_quiet("rst_after_release");
    press = 1'b1; sw_data = 8'h3C;
    @(negedge clk);
    press = 1'b0;
    @(negedge clk);
    expect_frame(8'h3C, 0);
    @(negedge clk);
    check_quiet("rst_clean_frame_end");
  endtask

`ifdef BTN_UART_PARITY_EN
  task automatic test_parity();
    press = 1'b1; sw_data = 8'h07;
    @(negedge clk);
    press = 1'b0;
    @(negedge clk);
    expect_frame(8'h07, 0);
    @(negedge clk);
    check_quiet("parity_07_end");
    press = 1'b1; sw_data = 8'h03;
    @(negedge clk);
    press = 1'b0;
    @(negedge clk);
    expect_frame(8'h03, 0);
    @(negedge clk);
    check_quiet("parity_03_end");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_push_pop();
    test_mid_frame_reset();
`ifdef BTN_UART_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/btn_uart_tx.md
Name: btn_uart_tx

Overview:
- Downstream consumer of the debounced button one-cycle `flag` pulse in the UART comm/display design.
- On each press pulse, captures the 8-bit switch value into a small FIFO.
- Serialises queued bytes as 8N1 UART frames on `tx`, LSB first.
- Lets operators send switch bytes to the host one press at a time without losing quick successive presses.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 9600, line rate; bit period DIV = CLK_FREQ/BAUD (integer truncation, 10416 at defaults).
- FIFO_DEPTH, 4, queued bytes; power of two, ≥2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- press  input  1  one-cycle debounced press pulse.
- sw_data  input  8  byte to enqueue, sampled on the press edge.
- tx  output  1  UART serial line, idles high.
- busy  output  1  high while a frame is in flight or the FIFO is non-empty.
- fifo_cnt  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  output  1  one-cycle pulse when a press is dropped because the FIFO is full.

Behaviour:
- Clock and reset: one clock `clk`; `rst` is asynchronous and active-low.
- Reset values while rst=0:
  - tx=1, busy=0, fifo_cnt=0, overflow=0.
  - FSM in IDLE; baud and bit counters cleared; FIFO pointers cleared.
  - Reset asserted mid-frame aborts the frame: tx goes high immediately and queued bytes are discarded.
- Enqueue:
  - On an edge with press=1 and FIFO not full, write sw_data; fifo_cnt increments on that edge.
  - press=1 with FIFO full: byte dropped, overflow=1 for exactly the next cycle, fifo_cnt unchanged.
  - press held high for several cycles enqueues once per cycle; the upstream pulse guarantees a single cycle.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. When fifo_cnt>0, pop the head into the shift register, load baud counter=0, go to START.
  - START: tx=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for DIV cycles, then shift right and increment the index; after index 7 completes, go to STOP.
  - STOP: tx=1 for DIV cycles, then go to IDLE.
  - Back-to-back frames: IDLE lasts exactly one cycle between frames.
- Latency: press sampled on edge N → byte in FIFO after N → pop and START entered on edge N+1 → tx falls after edge N+1.
- Frame length: 10·DIV cycles; tx is registered and glitch-free.
- Simultaneous push and pop on the same edge:
  - Occupancy unchanged.
  - When full, the push is accepted because the pop frees a slot.
  - When fifo_cnt=0, no pop occurs that edge; the pushed byte is popped on the following edge.
- Pointers wrap modulo FIFO_DEPTH; fifo_cnt never exceeds FIFO_DEPTH.
- busy = (state≠IDLE) | (fifo_cnt≠0).
- Widths:
  - Baud counter width $clog2(DIV); terminal at DIV-1.
  - Bit index is 3 bits.

Optional Feature:
- Macro: BTN_UART_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP.
  - tx = XOR of the 8 data bits (even parity) for DIV cycles.
  - Frame becomes 11·DIV cycles (8E1).
- Undefined: 8N1 as above; no parity logic synthesised.

Decomposition:
- Shared package uart_pkg:
  - State encoding constants ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_PARITY (2- or 3-bit localparams).
  - Data width constant UART_DW=8.
- One natural sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty/count), instantiated with width 8.
- FSM and baud counter stay in btn_uart_tx.

Test Plan (CLK_FREQ=1000000, BAUD=100000 → DIV=10):
- Single press with sw_data=0xA5 → tx low after 2 edges for 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, stop high 10 cycles; busy high for 101 cycles; fifo_cnt returns to 0.
- Presses 0x01,0x02,0x03 on consecutive cycles → three frames back-to-back with exactly 1 idle-high cycle between them, in order; fifo_cnt peaks at 2.
- Six presses within 6 cycles (depth 4, first popped immediately) → 5 bytes transmitted; overflow pulses once, on the 6th press; no frame is corrupted.
- Press exactly on the cycle FIFO is full while FSM pops → byte accepted, overflow stays 0, fifo_cnt stays 4.
- Assert rst=0 in the middle of DATA bit 3 → tx=1 asynchronously, busy=0, fifo_cnt=0. After release, a new press 0x3C sends a clean frame.
- With BTN_UART_PARITY_EN, sw_data=0x07 → parity bit 1; frame 110 cycles. With sw_data=0x03 → parity bit 0.
